// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU arbiter: operand width, ALU op codes,
// arbiter FSM states and the legal-op check.
package alu_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b100,
    XOR = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // Codes 110/111 have no ALU meaning and are answered with an error response.
  function automatic logic op_is_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    logic legal;
    case (alu_op_e'(ctrl))
      ADD, SUB, AND, OR, SLT, XOR: legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin grant: first asserted request found searching
// upward from ptr_i with wrap-around. The pointer itself lives in the parent.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               gnt_valid_o
);

  int   idx_s;
  logic hit_s;
  logic found_s;

  // Priority scan starting at the pointer; only the first hit is granted.
  always_comb begin
    gnt_o    = {NUM_REQ{1'b0}};
    gnt_id_o = {ID_W{1'b0}};
    found_s  = 1'b0;
    idx_s    = 0;
    hit_s    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s        = (int'(ptr_i) + k) % NUM_REQ;
      hit_s        = !found_s && req_i[idx_s];
      gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
      gnt_id_o     = hit_s ? ID_W'(idx_s) : gnt_id_o;
      found_s      = found_s | hit_s;
    end
    gnt_valid_o = found_s;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin grant
// and a tagged, registered response. Define ALU_ARB_STATS_EN for grant/stall counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*3-1:0]    req_ctrl,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_err,
  output logic [2:0]              Control_Line,
  output logic [XLEN-1:0]         SrcA,
  output logic [XLEN-1:0]         SrcB,
  input  logic [XLEN-1:0]         ALU_result,
  input  logic                    zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   grant_cnt,
  output logic [15:0]             stall_cnt
`endif
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic [ALU_CTRL_W-1:0] op_ctrl_q;
  logic [XLEN-1:0]       op_a_q;
  logic [XLEN-1:0]       op_b_q;
  logic [ID_W-1:0]       op_id_q;

  logic [ID_W-1:0] rsp_id_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;

  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic               gnt_valid_s;
  logic               hs_s;
  logic               op_legal_s;
  logic [ID_W-1:0]    ptr_next_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt_s),
    .gnt_id_o    (gnt_id_s),
    .gnt_valid_o (gnt_valid_s)
  );

  assign hs_s       = (state_q == ST_IDLE) && gnt_valid_s;
  assign op_legal_s = op_is_legal(op_ctrl_q);
  assign ptr_next_s = (int'(gnt_id_s) == NUM_REQ - 1) ? {ID_W{1'b0}} : gnt_id_s + ID_W'(1);

  // Next-state and ALU-port drive; ALU ports are parked at zero outside EXEC.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    req_ready    = {NUM_REQ{1'b0}};
    Control_Line = 3'b000;
    SrcA         = {XLEN{1'b0}};
    SrcB         = {XLEN{1'b0}};
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt_s;
        if (gnt_valid_s) begin
          state_d = ST_EXEC;
          ptr_d   = ptr_next_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        Control_Line = op_legal_s ? op_ctrl_q : 3'b000;
        SrcA         = op_a_q;
        SrcB         = op_b_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, operand latch on handshake and response capture after EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= {ID_W{1'b0}};
      op_ctrl_q    <= 3'b000;
      op_a_q       <= {XLEN{1'b0}};
      op_b_q       <= {XLEN{1'b0}};
      op_id_q      <= {ID_W{1'b0}};
      rsp_id_q     <= {ID_W{1'b0}};
      rsp_result_q <= {XLEN{1'b0}};
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (hs_s) begin
        op_ctrl_q <= req_ctrl[int'(gnt_id_s)*ALU_CTRL_W +: ALU_CTRL_W];
        op_a_q    <= req_a[int'(gnt_id_s)*XLEN +: XLEN];
        op_b_q    <= req_b[int'(gnt_id_s)*XLEN +: XLEN];
        op_id_q   <= gnt_id_s;
      end
      if (state_q == ST_EXEC) begin
        rsp_id_q     <= op_id_q;
        rsp_result_q <= op_legal_s ? ALU_result : {XLEN{1'b0}};
        rsp_zero_q   <= op_legal_s ? zero : 1'b1;
        rsp_err_q    <= !op_legal_s;
      end
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stall_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [15:0] cnt_q;

    // Saturating count of accepted requests for this requester.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= 16'h0000;
      end else if (hs_s && (gnt_id_s == ID_W'(gi)) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'h0001;
      end
    end

    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end

  // Saturating count of cycles where someone waits but nothing is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else if ((|req_valid) && !hs_s && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
